// File: rtl/slow_tick_timer_pkg.sv
// Shared types and constants for the slow-tick phase timer and the traffic-light FSM.
package traffic_pkg;

    localparam int unsigned PHASE_CNT_W = 8;

    // Phase lengths in seconds, shared with the light sequencer
    localparam int unsigned GREEN_S  = 10;
    localparam int unsigned YELLOW_S = 3;
    localparam int unsigned RED_S    = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } timer_state_t;

endpackage

// File: rtl/slow_tick_timer_if.sv
// Control/status bundle between the light FSM and the slow-tick phase timer.
interface slow_tick_timer_if
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W = PHASE_CNT_W
);
    logic             load;
    logic [CNT_W-1:0] load_value;
    logic             pause;
    logic             tick;
    logic [CNT_W-1:0] remaining;
    logic             busy;
    logic             expired;

    modport master (
        output load, load_value, pause,
        input  tick, remaining, busy, expired
    );

    modport slave (
        input  load, load_value, pause,
        output tick, remaining, busy, expired
    );
endinterface

// File: rtl/slow_tick_timer_sync.sv
// Synchronizes the slow clock into clk_in and emits one registered pulse per rising edge.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);
    localparam int unsigned            ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0]       ARM_LAST = ARM_W'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic                   armed_q, armed_d;
    logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
    logic                   rise_q, rise_d;

    // Arming waits until the edge register holds a real sample, so a level that
    // is already high at reset release is not mistaken for a rising edge.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], async_in};
        edge_d    = sync_q[SYNC_STAGES-1];
        arm_cnt_d = arm_cnt_q;
        if (!armed_q) begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end
        armed_d = armed_q | (arm_cnt_q == ARM_LAST);
        rise_d  = armed_q & sync_q[SYNC_STAGES-1] & ~edge_q;
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            sync_q    <= '0;
            edge_q    <= 1'b0;
            armed_q   <= 1'b0;
            arm_cnt_q <= '0;
            rise_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            edge_q    <= edge_d;
            armed_q   <= armed_d;
            arm_cnt_q <= arm_cnt_d;
            rise_q    <= rise_d;
        end
    end

    assign rise_pulse = rise_q;

endmodule

// File: rtl/slow_tick_timer.sv
// Phase timer counting synchronized slow_clk ticks; pulses expired when a loaded phase ends.
module slow_tick_timer
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W       = PHASE_CNT_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             slow_clk,
    slow_tick_timer_if.slave bus
);
    timer_state_t     state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             expired_q, expired_d;
    logic             busy_q, busy_d;
    logic             done_c;
    logic             tick_w;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_in    (clk_in),
        .reset     (reset),
        .async_in  (slow_clk),
        .rise_pulse(tick_w)
    );

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            expired_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            expired_q   <= expired_d;
            busy_q      <= busy_d;
        end
    end

    // Load outranks pause and tick; a zero-length load completes immediately.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_c      = 1'b0;
        if (bus.load) begin
            remaining_d = bus.load_value;
            if (bus.load_value == '0) begin
                state_d = IDLE;
                done_c  = 1'b1;
            end else if (bus.pause) begin
                state_d = HOLD;
            end else begin
                state_d = RUN;
            end
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                RUN: begin
                    if (bus.pause) begin
                        state_d = HOLD;
                    end else if (tick_w) begin
                        if (remaining_q > CNT_W'(1)) begin
                            remaining_d = remaining_q - CNT_W'(1);
                        end else begin
                            remaining_d = '0;
                            state_d     = IDLE;
                            done_c      = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!bus.pause) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        expired_d = done_c;
        busy_d    = (state_d != IDLE);
    end

    assign bus.tick      = tick_w;
    assign bus.remaining = remaining_q;
    assign bus.busy      = busy_q;
    assign bus.expired   = expired_q;

    a_busy_tracks_state: assert property (@(posedge clk_in) busy_q == (state_q != IDLE));
    a_expired_not_busy:  assert property (@(posedge clk_in) expired_q |-> !busy_q);

endmodule
